// File: rtl/sdrc_bank_req_que_if.sv
// Request-generator -> bank-control chunk interface, plus the head/pop port
// toward the bank/transfer sequencer.
interface sdrc_bank_req_que_if #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4,
  parameter int LEN_W = 12
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             r2b_req;
  logic [ID_W-1:0]  r2b_req_id;
  logic             r2b_start;
  logic             r2b_last;
  logic             r2b_wrap;
  logic             r2b_write;
  logic [1:0]       r2b_ba;
  logic [11:0]      r2b_raddr;
  logic [11:0]      r2b_caddr;
  logic [LEN_W-1:0] r2b_len;
  logic             b2r_ack;
  logic             b2r_arb_ok;

  logic             b2x_req;
  logic [ID_W-1:0]  b2x_req_id;
  logic             b2x_start;
  logic             b2x_last;
  logic             b2x_wrap;
  logic             b2x_write;
  logic [1:0]       b2x_ba;
  logic [11:0]      b2x_raddr;
  logic [11:0]      b2x_caddr;
  logic [LEN_W-1:0] b2x_len;
  logic             b2x_page_hit;
  logic             x2b_ack;
  logic             x2b_pre_all;
  logic [CNT_W-1:0] b2x_count;

  modport master (
    output r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
           r2b_ba, r2b_raddr, r2b_caddr, r2b_len, x2b_ack, x2b_pre_all,
    input  b2r_ack, b2r_arb_ok, b2x_req, b2x_req_id, b2x_start, b2x_last,
           b2x_wrap, b2x_write, b2x_ba, b2x_raddr, b2x_caddr, b2x_len,
           b2x_page_hit, b2x_count
  );

  modport slave (
    input  r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
           r2b_ba, r2b_raddr, r2b_caddr, r2b_len, x2b_ack, x2b_pre_all,
    output b2r_ack, b2r_arb_ok, b2x_req, b2x_req_id, b2x_start, b2x_last,
           b2x_wrap, b2x_write, b2x_ba, b2x_raddr, b2x_caddr, b2x_len,
           b2x_page_hit, b2x_count
  );
endinterface

// File: rtl/sdrc_bank_req_que.sv
// Front of bank control: in-order chunk FIFO from the request generator,
// with per-bank open-row tracking to flag page hits on the head entry.
module sdrc_bank_req_que #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4,
  parameter int LEN_W = 12
) (
  input logic                clk,
  input logic                reset_n,
  sdrc_bank_req_que_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ID_W + 4 + 2 + 12 + 12 + LEN_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       row_valid_q, row_valid_d;
  logic [11:0]      open_row_q [4];
  logic [11:0]      open_row_d [4];

  logic             full, empty, push, pop;
  logic [ENT_W-1:0] wdata, head;
  logic [1:0]       head_ba;
  logic [11:0]      head_raddr;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // Gated by reset_n so no chunk is acked while the queue is held in reset.
  assign push  = bus.r2b_req & ~full & reset_n;
  assign pop   = bus.x2b_ack & ~empty;

  assign wdata = {bus.r2b_req_id, bus.r2b_start, bus.r2b_last, bus.r2b_wrap,
                  bus.r2b_write, bus.r2b_ba, bus.r2b_raddr, bus.r2b_caddr,
                  bus.r2b_len};
  assign head  = mem_q[rd_ptr_q];

  assign {bus.b2x_req_id, bus.b2x_start, bus.b2x_last, bus.b2x_wrap,
          bus.b2x_write, head_ba, head_raddr, bus.b2x_caddr,
          bus.b2x_len} = head;
  assign bus.b2x_ba    = head_ba;
  assign bus.b2x_raddr = head_raddr;

  assign bus.b2r_ack      = push;
  assign bus.b2r_arb_ok   = ~full;
  assign bus.b2x_req      = ~empty;
  assign bus.b2x_count    = count_q;
  assign bus.b2x_page_hit = ~empty & row_valid_q[head_ba] &
                            (open_row_q[head_ba] == head_raddr);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Precharge-all clears first so a same-cycle pop still opens its row.
  always_comb begin
    row_valid_d = row_valid_q;
    open_row_d  = open_row_q;
    if (bus.x2b_pre_all) row_valid_d = '0;
    if (pop) begin
      row_valid_d[head_ba] = 1'b1;
      open_row_d[head_ba]  = head_raddr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      row_valid_q <= '0;
      open_row_q  <= '{default: '0};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      row_valid_q <= row_valid_d;
      open_row_q  <= open_row_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: tb/tb_sdrc_bank_req_que.sv
// Randomized + directed bench for sdrc_bank_req_que with a queue-based
// reference model and a negedge scoreboard monitor.
module tb_sdrc_bank_req_que;
  localparam int DEPTH = 4;
  localparam int ID_W  = 4;
  localparam int LEN_W = 12;

  typedef struct packed {
    logic [3:0]  id;
    logic        start;
    logic        last;
    logic        wrap;
    logic        write;
    logic [1:0]  ba;
    logic [11:0] raddr;
    logic [11:0] caddr;
    logic [11:0] len;
  } chunk_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  bit   acc;
  int   n_chk = 0;
  int   n_err = 0;

  chunk_t      mq[$];
  bit          rv[4];
  logic [11:0] orow[4];

  sdrc_bank_req_que_if #(.DEPTH(DEPTH), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

  sdrc_bank_req_que #(.DEPTH(DEPTH), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: expectations come from the model queue and page table only.
  always @(negedge clk) begin
    chunk_t h, in;
    bit     e_arb, e_ack, e_req, e_hit;
    if (!reset_n) begin
      mq.delete();
      foreach (rv[i]) begin rv[i] = 1'b0; orow[i] = '0; end
      chk("rst_ack",    bus.b2r_ack, 0);
      chk("rst_arb_ok", bus.b2r_arb_ok, 1);
      chk("rst_req",    bus.b2x_req, 0);
      chk("rst_count",  bus.b2x_count, 0);
      chk("rst_hit",    bus.b2x_page_hit, 0);
    end else begin
      e_arb = (mq.size() < DEPTH);
      e_ack = bus.r2b_req && e_arb;
      e_req = (mq.size() != 0);
      chk("arb_ok", bus.b2r_arb_ok, e_arb);
      chk("ack",    bus.b2r_ack, e_ack);
      chk("req",    bus.b2x_req, e_req);
      chk("count",  bus.b2x_count, mq.size());
      e_hit = 1'b0;
      if (e_req) begin
        h = mq[0];
        e_hit = rv[h.ba] && (orow[h.ba] == h.raddr);
        chk("head", {bus.b2x_req_id, bus.b2x_start, bus.b2x_last, bus.b2x_wrap,
                     bus.b2x_write, bus.b2x_ba, bus.b2x_raddr, bus.b2x_caddr,
                     bus.b2x_len}, h);
      end
      chk("page_hit", bus.b2x_page_hit, e_hit);
      if (bus.x2b_pre_all) foreach (rv[i]) rv[i] = 1'b0;
      if (e_req && bus.x2b_ack) begin
        rv[h.ba]   = 1'b1;
        orow[h.ba] = h.raddr;
        void'(mq.pop_front());
      end
      if (e_ack) begin
        in = {bus.r2b_req_id, bus.r2b_start, bus.r2b_last, bus.r2b_wrap,
              bus.r2b_write, bus.r2b_ba, bus.r2b_raddr, bus.r2b_caddr, bus.r2b_len};
        mq.push_back(in);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    acc = bus.r2b_req && bus.b2r_ack;
    @(posedge clk);
    #1;
  endtask

  task automatic set_chunk(input logic [3:0] id, input logic s, input logic l,
                           input logic [1:0] ba, input logic [11:0] ra,
                           input logic [11:0] len);
    bus.r2b_req    = 1'b1;
    bus.r2b_req_id = id;
    bus.r2b_start  = s;
    bus.r2b_last   = l;
    bus.r2b_wrap   = 1'($urandom);
    bus.r2b_write  = 1'($urandom);
    bus.r2b_ba     = ba;
    bus.r2b_raddr  = ra;
    bus.r2b_caddr  = 12'($urandom);
    bus.r2b_len    = len;
  endtask

  task automatic push_wait();
    for (int n = 0; n < 30; n++) begin
      step();
      if (acc) break;
    end
    if (!acc) begin
      n_chk++;
      n_err++;
      $display("FAIL push_timeout actual=no_ack expected=ack t=%0t", $time);
    end
    bus.r2b_req = 1'b0;
  endtask

  task automatic push(input logic [1:0] ba, input logic [11:0] ra);
    set_chunk(4'($urandom), 1'b1, 1'b1, ba, ra, 12'($urandom));
    push_wait();
  endtask

  task automatic pop1();
    bus.x2b_ack = 1'b1;
    step();
    bus.x2b_ack = 1'b0;
  endtask

  task automatic drain();
    bus.x2b_ack = 1'b1;
    repeat (DEPTH + 2) step();
    bus.x2b_ack = 1'b0;
  endtask

  initial begin
    bus.x2b_ack     = 1'b0;
    bus.x2b_pre_all = 1'b0;
    set_chunk(4'h1, 1'b1, 1'b1, 2'd0, 12'h000, 12'h001);
    repeat (3) @(posedge clk);
    #1;
    reset_n     = 1'b1;
    bus.r2b_req = 1'b0;
    step();

    // Fill to full, hold a fifth request, then pop while full.
    for (int i = 0; i < 4; i++) push(2'd1, 12'h010 + 12'(i));
    set_chunk(4'h7, 1'b1, 1'b1, 2'd1, 12'h014, 12'h004);
    repeat (3) step();
    bus.x2b_ack = 1'b1;
    step();
    bus.x2b_ack = 1'b0;
    step();
    if (!acc) begin
      n_chk++;
      n_err++;
      $display("FAIL refill_ack actual=0 expected=1 t=%0t", $time);
    end else n_chk++;
    bus.r2b_req = 1'b0;
    drain();

    // Two-chunk burst.
    set_chunk(4'h5, 1'b1, 1'b0, 2'd3, 12'h200, 12'h0F0);
    push_wait();
    set_chunk(4'h5, 1'b0, 1'b1, 2'd3, 12'h201, 12'h010);
    push_wait();
    step();
    drain();

    // Page hit / miss / precharge-all.
    push(2'd2, 12'h0AB);
    push(2'd2, 12'h0AB);
    push(2'd2, 12'h0AC);
    pop1();
    step();
    pop1();
    step();
    drain();
    bus.x2b_pre_all = 1'b1;
    step();
    bus.x2b_pre_all = 1'b0;
    push(2'd2, 12'h0AB);
    step();
    drain();

    // Precharge-all coincident with a pop.
    push(2'd0, 12'h123);
    push(2'd0, 12'h123);
    push(2'd3, 12'h123);
    bus.x2b_ack     = 1'b1;
    bus.x2b_pre_all = 1'b1;
    step();
    bus.x2b_ack     = 1'b0;
    bus.x2b_pre_all = 1'b0;
    step();
    pop1();
    step();
    drain();

    // Asynchronous reset mid-operation with a request pending.
    push(2'd1, 12'h055);
    push(2'd2, 12'h066);
    set_chunk(4'h9, 1'b1, 1'b1, 2'd0, 12'h077, 12'h008);
    #2 reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    push_wait();
    step();
    drain();

    // Randomized traffic with a held-until-acked generator.
    acc = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (!bus.r2b_req || acc) begin
        if ($urandom_range(0, 3) != 0)
          set_chunk(4'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                    12'($urandom_range(0, 3)), 12'($urandom));
        else
          bus.r2b_req = 1'b0;
      end
      bus.x2b_ack     = 1'($urandom_range(0, 2) != 0);
      bus.x2b_pre_all = ($urandom_range(0, 15) == 0);
      step();
    end
    bus.r2b_req     = 1'b0;
    bus.x2b_pre_all = 1'b0;
    drain();
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
